// File: rtl/link_cfg.sv
// Shared constants and types for the link FIFO read side.
// Holds the link FIFO geometry, the drain burst limit and skid depth,
// the drain FSM state type and the source tag type.
package link_cfg;

  localparam int CTL_LINK_FIFO_DATA_WIDTH = 256;
  localparam int DAT_LINK_FIFO_DATA_WIDTH = 256;
  localparam int CTL_LINK_FIFO_ADDR_WIDTH = 10;
  localparam int DAT_LINK_FIFO_ADDR_WIDTH = 12;

  localparam int LINK_DRAIN_MAX_BURST  = 16;
  localparam int LINK_DRAIN_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CTL_BURST = 2'd1,
    DAT_BURST = 2'd2
  } link_drain_state_t;

  typedef enum logic {
    SRC_DAT = 1'b0,
    SRC_CTL = 1'b1
  } link_src_t;

  // Burst length for a given fill level: never more than the FIFO holds,
  // never more than the burst limit. Burst limit is at most 255.
  function automatic logic [7:0] burst_clamp(input logic [31:0] level,
                                             input logic [31:0] max_burst);
    if (level > max_burst) begin
      return max_burst[7:0];
    end
    return level[7:0];
  endfunction

endpackage

// File: rtl/link_drain_skid.sv
// Purpose: 2-entry {data, src, last} buffer between FIFO read data and the output stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: head held stable while out_valid && !out_ready; the producer meters
//               pushes with the occupancy output so a push never meets a full buffer.
// Ports: clk, rst (sync, active high); push/push_data/push_src/push_last in;
//        out_valid/out_data/out_src/out_last out with out_ready in; occupancy out.
module link_drain_skid
  import link_cfg::*;
#(
  parameter int DATA_WIDTH = DAT_LINK_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  link_src_t             push_src,
  input  logic                  push_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output link_src_t             out_src,
  output logic                  out_last,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] data_q [2];
  link_src_t             src_q  [2];
  logic                  last_q [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = data_q[rd_ptr];
  assign out_src   = src_q[rd_ptr];
  assign out_last  = last_q[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        src_q[i]  <= SRC_DAT;
        last_q[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        src_q[wr_ptr]  <= push_src;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The drain credit scheme must never deliver a word into a full buffer.
  skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == 2'(LINK_DRAIN_SKID_DEPTH))));

endmodule

// File: rtl/link_fifo_drain.sv
// Purpose: drains the ctl and dat link FIFOs in bursts (ctl first at burst boundaries)
//          into one valid/ready stream tagged with source and burst-last.
// Latency: 2 clk from rd_en to out_valid; 1 word/clk sustained; 1 idle cycle per burst.
// Backpressure: pops are credit-limited to the 2-entry skid, so out_ready low stalls
//               issue with at most 2 words outstanding and the output held stable.
// Ports: clk, rst (sync, active high), drain_en; ctl_/dat_ usedw in, rd_en out, rd_data in;
//        out_valid/out_data/out_src/out_last out, out_ready in; ctl_words/dat_words out, stats_clr in.
// Option: LINK_DRAIN_STATS_EN adds the delivered-word counters; otherwise they read 0.
module link_fifo_drain
  import link_cfg::*;
#(
  parameter int DATA_WIDTH     = CTL_LINK_FIFO_DATA_WIDTH,
  parameter int CTL_ADDR_WIDTH = CTL_LINK_FIFO_ADDR_WIDTH,
  parameter int DAT_ADDR_WIDTH = DAT_LINK_FIFO_ADDR_WIDTH,
  parameter int MAX_BURST      = LINK_DRAIN_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drain_en,
  input  logic [CTL_ADDR_WIDTH:0] ctl_usedw,
  output logic                    ctl_rd_en,
  input  logic [DATA_WIDTH-1:0]   ctl_rd_data,
  input  logic [DAT_ADDR_WIDTH:0] dat_usedw,
  output logic                    dat_rd_en,
  input  logic [DATA_WIDTH-1:0]   dat_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_src,
  output logic                    out_last,
  output logic [31:0]             ctl_words,
  output logic [31:0]             dat_words,
  input  logic                    stats_clr
);

  link_drain_state_t state, state_nxt;
  logic [7:0]        burst_len, burst_len_nxt;
  logic [7:0]        issue_cnt, issue_cnt_nxt;

  logic              rd_pend;     // a pop issued last cycle; its data is on rd_data now
  link_src_t         pend_src;
  logic              pend_last;

  logic [1:0]        occ;
  logic              pop_out;
  logic [2:0]        in_use;
  logic [2:0]        room;
  logic              credit_ok;
  logic              in_burst;
  logic              issue;
  logic              issue_last;

  link_src_t             skid_src;
  logic [DATA_WIDTH-1:0] push_data;

  assign pop_out = out_valid && out_ready;

  // Words held or on their way must fit in the skid, counting the slot
  // freed by an output accepted this same cycle.
  assign in_use    = {1'b0, occ} + {2'b0, rd_pend};
  assign room      = 3'(LINK_DRAIN_SKID_DEPTH) + {2'b0, pop_out};
  assign credit_ok = (in_use < room);

  assign in_burst   = (state == CTL_BURST) || (state == DAT_BURST);
  assign issue      = in_burst && (issue_cnt < burst_len) && credit_ok && !rst;
  assign issue_last = issue && ((issue_cnt + 8'd1) == burst_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_len <= 8'd0;
      issue_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      burst_len <= burst_len_nxt;
      issue_cnt <= issue_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_len_nxt = burst_len;
    issue_cnt_nxt = issue_cnt;
    ctl_rd_en     = 1'b0;
    dat_rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (drain_en) begin
          if (ctl_usedw != '0) begin
            state_nxt     = CTL_BURST;
            burst_len_nxt = burst_clamp(32'(ctl_usedw), 32'(MAX_BURST));
            issue_cnt_nxt = 8'd0;
          end else if (dat_usedw != '0) begin
            state_nxt     = DAT_BURST;
            burst_len_nxt = burst_clamp(32'(dat_usedw), 32'(MAX_BURST));
            issue_cnt_nxt = 8'd0;
          end
        end
      end
      CTL_BURST, DAT_BURST: begin
        ctl_rd_en = issue && (state == CTL_BURST);
        dat_rd_en = issue && (state == DAT_BURST);
        if (issue) begin
          issue_cnt_nxt = issue_cnt + 8'd1;
        end
        // Always drop back to IDLE after the final pop, so priority is
        // re-evaluated between every pair of bursts.
        if (issue_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tags travel alongside the 1-cycle FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      pend_src  <= SRC_DAT;
      pend_last <= 1'b0;
    end else begin
      rd_pend   <= issue;
      pend_src  <= (state == CTL_BURST) ? SRC_CTL : SRC_DAT;
      pend_last <= issue_last;
    end
  end

  assign push_data = (pend_src == SRC_CTL) ? ctl_rd_data : dat_rd_data;

  link_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (push_data),
    .push_src  (pend_src),
    .push_last (pend_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (skid_src),
    .out_last  (out_last),
    .occupancy (occ)
  );

  assign out_src = (skid_src == SRC_CTL);

`ifdef LINK_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      ctl_words <= 32'd0;
      dat_words <= 32'd0;
    end else if (pop_out) begin
      if (out_src) begin
        ctl_words <= ctl_words + 32'd1;
      end else begin
        dat_words <= dat_words + 32'd1;
      end
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign ctl_words = 32'd0;
  assign dat_words = 32'd0;
`endif

endmodule

// File: tb/tb_link_fifo_drain.sv
`timescale 1ns/1ps
module tb_link_fifo_drain;

  localparam int DW = 256;
  localparam int CA = 10;
  localparam int DA = 12;
  localparam int MB = 16;
`ifdef LINK_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          drain_en;
  logic [CA:0]   ctl_usedw;
  logic          ctl_rd_en;
  logic [DW-1:0] ctl_rd_data;
  logic [DA:0]   dat_usedw;
  logic          dat_rd_en;
  logic [DW-1:0] dat_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_last;
  logic [31:0]   ctl_words;
  logic [31:0]   dat_words;
  logic          stats_clr;

  always #5 clk = ~clk;

  link_fifo_drain dut (
    .clk(clk), .rst(rst), .drain_en(drain_en),
    .ctl_usedw(ctl_usedw), .ctl_rd_en(ctl_rd_en), .ctl_rd_data(ctl_rd_data),
    .dat_usedw(dat_usedw), .dat_rd_en(dat_rd_en), .dat_rd_data(dat_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_last(out_last),
    .ctl_words(ctl_words), .dat_words(dat_words), .stats_clr(stats_clr)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          l;
  } item_t;

  logic [DW-1:0] ctl_q[$], dat_q[$];       // FIFO contents
  logic [DW-1:0] ctl_new[$], dat_new[$];   // pushed but not yet scheduled
  item_t         exp_q[$];                 // expected output order

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  pops = 0;
  int  accepted = 0;
  int  pop_cyc[$];
  int  first_valid_cyc = -1;
  bit  ctl_pop_s, dat_pop_s;
  bit  rand_mode = 1'b0;
  bit  rnd_ready = 1'b1;
  bit  ready_hold = 1'b1;
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_src, prev_last;
  logic [31:0] m_ctl = 0, m_dat = 0;

  assign out_ready = rand_mode ? rnd_ready : ready_hold;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Per-cycle observation at the falling edge.
  task automatic monitor();
    bit acc;
    ctl_pop_s = ctl_rd_en;
    dat_pop_s = dat_rd_en;
    if (rst) begin
      prev_stall = 1'b0;
      m_ctl = 0;
      m_dat = 0;
      return;
    end
    if (ctl_rd_en) begin
      pops++;
      pop_cyc.push_back(cyc);
      chk_int("ctl_pop_nonempty", int'(ctl_q.size() != 0), 1);
    end
    if (dat_rd_en) begin
      pops++;
      pop_cyc.push_back(cyc);
      chk_int("dat_pop_nonempty", int'(dat_q.size() != 0), 1);
    end
    if (ctl_rd_en && dat_rd_en) chk_int("single_pop", 2, 1);
    if (prev_stall) begin
      chk_int("stall_valid", int'(out_valid), 1);
      chk("stall_data", out_data, prev_data);
      chk_int("stall_tags", int'({out_src, out_last}), int'({prev_src, prev_last}));
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    acc = out_valid && out_ready;
    if (acc) begin
      accepted++;
      if (exp_q.size() == 0) begin
        chk_int("unexpected_word", 1, 0);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk_int("out_src", int'(out_src), int'(e.s));
        chk_int("out_last", int'(out_last), int'(e.l));
      end
    end
    if (stats_clr) begin
      m_ctl = 0;
      m_dat = 0;
    end else if (acc) begin
      if (out_src) m_ctl = m_ctl + 1;
      else         m_dat = m_dat + 1;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_src   = out_src;
    prev_last  = out_last;
  endtask

  // One clock: observe, then model the FIFO read side at the edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    if (ctl_pop_s && ctl_q.size() != 0) ctl_rd_data <= ctl_q.pop_front();
    if (dat_pop_s && dat_q.size() != 0) dat_rd_data <= dat_q.pop_front();
    ctl_usedw <= (CA+1)'(ctl_q.size());
    dat_usedw <= (DA+1)'(dat_q.size());
    #1;
    if (rand_mode) rnd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input bit src, input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      for (int j = 0; j < DW/32; j++) w[j*32 +: 32] = $urandom();
      if (src) begin ctl_q.push_back(w); ctl_new.push_back(w); end
      else     begin dat_q.push_back(w); dat_new.push_back(w); end
    end
    ctl_usedw = (CA+1)'(ctl_q.size());
    dat_usedw = (DA+1)'(dat_q.size());
  endtask

  // Expected stream for `total` words of one source: bursts of at most MB, last on each burst end.
  task automatic sched(input bit src, input int total);
    int left;
    left = total;
    while (left > 0) begin
      int n;
      n = (left > MB) ? MB : left;
      for (int k = 0; k < n; k++) begin
        item_t e;
        e.d = src ? ctl_new.pop_front() : dat_new.pop_front();
        e.s = src;
        e.l = (k == n - 1);
        exp_q.push_back(e);
      end
      left -= n;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk_int(tag, exp_q.size(), 0);
    repeat (4) tick();
    drain_en = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
    chk_int({tag, "_ctl"}, int'(ctl_words), STATS ? int'(m_ctl) : 0);
    chk_int({tag, "_dat"}, int'(dat_words), STATS ? int'(m_dat) : 0);
  endtask

  initial begin
    int base, n, c, d;
    rst = 1'b1; drain_en = 1'b0; stats_clr = 1'b0;
    ctl_usedw = '0; dat_usedw = '0; ctl_rd_data = '0; dat_rd_data = '0;
    repeat (3) tick();
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_rd_en", int'({ctl_rd_en, dat_rd_en}), 0);
    chk("rst_out_data", out_data, '0);
    chk_int("rst_tags", int'({out_src, out_last}), 0);
    chk_stats("rst_stats");
    rst = 1'b0;
    repeat (2) tick();

    // 3 ctl words: back-to-back pops, 2 clk to first valid, last on 3rd.
    pop_cyc.delete(); first_valid_cyc = -1;
    push(1'b1, 3); sched(1'b1, 3);
    drain_en = 1'b1;
    wait_drain("t1_drain", 200);
    chk_int("t1_pops", pop_cyc.size(), 3);
    chk_int("t1_pop_gap1", pop_cyc[1] - pop_cyc[0], 1);
    chk_int("t1_pop_gap2", pop_cyc[2] - pop_cyc[1], 1);
    chk_int("t1_latency", first_valid_cyc - pop_cyc[0], 2);

    // 40 dat words: bursts 16/16/8 with one bubble between bursts.
    pop_cyc.delete();
    push(1'b0, 40); sched(1'b0, 40);
    drain_en = 1'b1;
    wait_drain("t2_drain", 400);
    chk_int("t2_pops", pop_cyc.size(), 40);
    chk_int("t2_burst1_span", pop_cyc[15] - pop_cyc[0], 15);
    chk_int("t2_bubble1", pop_cyc[16] - pop_cyc[15], 2);
    chk_int("t2_bubble2", pop_cyc[32] - pop_cyc[31], 2);
    chk_int("t2_burst3_span", pop_cyc[39] - pop_cyc[32], 7);

    // ctl arrives mid dat burst: dat 16, ctl 2, dat 16 + 8.
    push(1'b0, 40); sched(1'b0, 16);
    base = accepted; n = 0;
    drain_en = 1'b1;
    while (accepted == base && n < 50) begin tick(); n++; end
    chk_int("t3_started", int'(accepted > base), 1);
    push(1'b1, 2); sched(1'b1, 2); sched(1'b0, 24);
    wait_drain("t3_drain", 400);

    // Stall for 10 clks: exactly 2 words outstanding, output held.
    push(1'b0, 20); sched(1'b0, 20);
    base = pops; n = 0;
    drain_en = 1'b1;
    while (pops - base < 4 && n < 50) begin tick(); n++; end
    ready_hold = 1'b0;
    repeat (10) tick();
    chk_int("t4_outstanding", pops - accepted, 2);
    chk_int("t4_no_pop", int'({ctl_rd_en, dat_rd_en}), 0);
    chk_int("t4_held_valid", int'(out_valid), 1);
    ready_hold = 1'b1;
    wait_drain("t4_drain", 400);

    // drain_en drops mid-burst: the burst finishes, no new one starts.
    push(1'b0, 40); sched(1'b0, 40);
    base = pops; n = 0;
    drain_en = 1'b1;
    while (pops - base < 5 && n < 50) begin tick(); n++; end
    drain_en = 1'b0;
    repeat (30) tick();
    chk_int("t5_pops_one_burst", pops - base, 16);
    chk_int("t5_remaining", exp_q.size(), 24);
    drain_en = 1'b1;
    wait_drain("t5_drain", 400);

    // Counters, then clear in the same cycle as an accepted word.
    chk_stats("t6_stats");
    push(1'b0, 5); sched(1'b0, 5);
    drain_en = 1'b1; n = 0;
    while (!(out_valid && out_ready) && n < 50) begin tick(); n++; end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk_int("t6_clr_vs_inc", int'(dat_words), 0);
    wait_drain("t6_drain", 200);
    chk_stats("t6_after_clr");

    // Reset mid-burst, then a clean 1-word ctl burst.
    push(1'b1, 10); sched(1'b1, 10);
    base = accepted; n = 0;
    drain_en = 1'b1;
    while (accepted - base < 3 && n < 50) begin tick(); n++; end
    rst = 1'b1;
    ctl_q.delete(); dat_q.delete(); ctl_new.delete(); dat_new.delete(); exp_q.delete();
    ctl_usedw = '0; dat_usedw = '0;
    tick();
    chk_int("t7_rst_valid", int'(out_valid), 0);
    chk_int("t7_rst_rd_en", int'({ctl_rd_en, dat_rd_en}), 0);
    chk("t7_rst_data", out_data, '0);
    chk_int("t7_rst_tags", int'({out_src, out_last}), 0);
    rst = 1'b0;
    tick();
    base = pops;
    push(1'b1, 1); sched(1'b1, 1);
    wait_drain("t7_drain", 200);
    chk_int("t7_single_pop", pops - base, 1);

    // Random fills and random backpressure.
    rand_mode = 1'b1;
    for (int it = 0; it < 6; it++) begin
      c = $urandom_range(0, 20);
      d = $urandom_range(0, 40);
      push(1'b1, c); push(1'b0, d);
      sched(1'b1, c); sched(1'b0, d);
      drain_en = 1'b1;
      wait_drain("rand_drain", 2000);
    end
    rand_mode = 1'b0;
    chk_stats("final_stats");
    chk_int("final_fifos_empty", ctl_q.size() + dat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
